// File: rtl/rv3n_bridge_pkg.sv
// rtl/rv3n_bridge_pkg.sv - shared types and helpers for the rv3n dmem-to-Wishbone bridge
//
// Contents:
//   width_e    : access width encoding of dmem_width (BYTE/HALF/WORD/RSVD)
//   state_e    : bridge FSM states (IDLE/BUS/RESP)
//   sel_gen    : byte-select pattern for a width and byte offset
//   misaligned : true when an access cannot be issued as a single Wishbone cycle
package rv3n_bridge_pkg;

    typedef enum logic [1:0] {
        BYTE = 2'b00,
        HALF = 2'b01,
        WORD = 2'b10,
        RSVD = 2'b11
    } width_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        BUS  = 2'b01,
        RESP = 2'b10
    } state_e;

    function automatic logic [3:0] sel_gen(width_e w, logic [1:0] off);
        logic [3:0] sel;
        case (w)
            BYTE:    sel = 4'b0001 << off;
            HALF:    sel = 4'b0011 << off;
            WORD:    sel = 4'b1111;
            default: sel = 4'b0000;
        endcase
        return sel;
    endfunction

    function automatic logic misaligned(width_e w, logic [1:0] off);
        logic bad;
        case (w)
            BYTE:    bad = 1'b0;
            HALF:    bad = off[0];
            WORD:    bad = (off != 2'b00);
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/rv3n_dmem_wb_bridge_if.sv
// rtl/rv3n_dmem_wb_bridge_if.sv - Wishbone master bus bundle for the rv3n dmem bridge
//
// Signals:
//   wb_cyc_o, wb_stb_o, wb_we_o : cycle / strobe / write-enable from the master
//   wb_sel_o [3:0]              : byte selects
//   wb_adr_o [31:0]             : word-aligned address
//   wb_dat_o [31:0]             : lane-steered write data
//   wb_dat_i [31:0]             : read data from the slave
//   wb_ack_i                    : acknowledge from the slave
// Modports: master (bridge side), slave (memory / bench side).
interface rv3n_dmem_wb_bridge_if;
    logic        wb_cyc_o;
    logic        wb_stb_o;
    logic        wb_we_o;
    logic [3:0]  wb_sel_o;
    logic [31:0] wb_adr_o;
    logic [31:0] wb_dat_o;
    logic [31:0] wb_dat_i;
    logic        wb_ack_i;

    modport master (
        output wb_cyc_o, wb_stb_o, wb_we_o, wb_sel_o, wb_adr_o, wb_dat_o,
        input  wb_dat_i, wb_ack_i
    );

    modport slave (
        input  wb_cyc_o, wb_stb_o, wb_we_o, wb_sel_o, wb_adr_o, wb_dat_o,
        output wb_dat_i, wb_ack_i
    );
endinterface

// File: rtl/rv3n_lane_steer.sv
// rtl/rv3n_lane_steer.sv - combinational byte-lane steering for the rv3n dmem bridge
//
// Ports:
//   req_width_i, req_off_i, req_wdata_i : incoming request width, byte offset, right-aligned data
//   req_sel_o, req_wdata_o              : Wishbone byte selects and lane-replicated write data
//   rsp_width_i, rsp_off_i              : width/offset of the outstanding access
//   bus_rdata_i                         : raw Wishbone read data
//   rsp_rdata_o                         : right-aligned, zero-extended read data
module rv3n_lane_steer
    import rv3n_bridge_pkg::*;
(
    input  width_e      req_width_i,
    input  logic [1:0]  req_off_i,
    input  logic [31:0] req_wdata_i,
    output logic [3:0]  req_sel_o,
    output logic [31:0] req_wdata_o,
    input  width_e      rsp_width_i,
    input  logic [1:0]  rsp_off_i,
    input  logic [31:0] bus_rdata_i,
    output logic [31:0] rsp_rdata_o
);
    logic [31:0] shifted;

    always_comb begin
        req_sel_o = sel_gen(req_width_i, req_off_i);
        // Replicate the narrow datum across all lanes; sel picks the live lane.
        case (req_width_i)
            BYTE:    req_wdata_o = {4{req_wdata_i[7:0]}};
            HALF:    req_wdata_o = {2{req_wdata_i[15:0]}};
            default: req_wdata_o = req_wdata_i;
        endcase
    end

    always_comb begin
        shifted = bus_rdata_i >> {rsp_off_i, 3'b000};
        case (rsp_width_i)
            BYTE:    rsp_rdata_o = {24'h000000, shifted[7:0]};
            HALF:    rsp_rdata_o = {16'h0000, shifted[15:0]};
            default: rsp_rdata_o = shifted;
        endcase
    end
endmodule

// File: rtl/rv3n_dmem_wb_bridge.sv
// rtl/rv3n_dmem_wb_bridge.sv - rv3n dmem port to single-outstanding pipelined Wishbone master
//
// Ports:
//   clk, rst_n                         : core clock, asynchronous active-low reset
//   dmem_req/cmd/width/addr/wdata      : core request (held by the core until dmem_resp)
//   dmem_rdata, dmem_resp, dmem_err    : one-cycle completion pulse with data/error
//   wb (rv3n_dmem_wb_bridge_if.master) : Wishbone master bus
// Parameter TIMEOUT_CYCLES : BUS cycles without ack before an error response.
// Build option BRIDGE_TIMEOUT_EN : compiles in the bus-timeout watchdog.
module rv3n_dmem_wb_bridge
    import rv3n_bridge_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        dmem_req,
    input  logic        dmem_cmd,
    input  logic [1:0]  dmem_width,
    input  logic [31:0] dmem_addr,
    input  logic [31:0] dmem_wdata,
    output logic [31:0] dmem_rdata,
    output logic        dmem_resp,
    output logic        dmem_err,
    rv3n_dmem_wb_bridge_if.master wb
);
    state_e      state_q, state_d;
    logic        cyc_q, cyc_d, stb_q, stb_d, we_q, we_d;
    logic [3:0]  sel_q, sel_d;
    logic [31:0] adr_q, adr_d, dat_q, dat_d, rdata_q, rdata_d;
    logic        resp_q, resp_d, err_q, err_d;
    width_e      wid_q, wid_d;
    logic [1:0]  off_q, off_d;

    width_e      req_width;
    logic        req_bad;
    logic [3:0]  steer_sel;
    logic [31:0] steer_wdata, steer_rdata;
    logic        expire;

    assign req_width = width_e'(dmem_width);
    assign req_bad   = misaligned(req_width, dmem_addr[1:0]);

    rv3n_lane_steer u_steer (
        .req_width_i (req_width),
        .req_off_i   (dmem_addr[1:0]),
        .req_wdata_i (dmem_wdata),
        .req_sel_o   (steer_sel),
        .req_wdata_o (steer_wdata),
        .rsp_width_i (wid_q),
        .rsp_off_i   (off_q),
        .bus_rdata_i (wb.wb_dat_i),
        .rsp_rdata_o (steer_rdata)
    );

`ifdef BRIDGE_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Fires on the BUS cycle that would bring the no-ack count to TIMEOUT_CYCLES.
    assign expire = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

    always_comb begin
        cnt_d = cnt_q;
        if (state_q == IDLE) begin
            cnt_d = '0;
        end else if (state_q == BUS && !wb.wb_ack_i) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end
`else
    assign expire = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (dmem_req) state_d = req_bad ? RESP : BUS;
            BUS:     if (wb.wb_ack_i || expire) state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        cyc_d   = cyc_q;
        stb_d   = stb_q;
        we_d    = we_q;
        sel_d   = sel_q;
        adr_d   = adr_q;
        dat_d   = dat_q;
        rdata_d = rdata_q;
        wid_d   = wid_q;
        off_d   = off_q;
        resp_d  = 1'b0;
        err_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (dmem_req) begin
                    if (req_bad) begin
                        resp_d  = 1'b1;
                        err_d   = 1'b1;
                        rdata_d = '0;
                    end else begin
                        cyc_d = 1'b1;
                        stb_d = 1'b1;
                        we_d  = dmem_cmd;
                        sel_d = steer_sel;
                        adr_d = {dmem_addr[31:2], 2'b00};
                        dat_d = steer_wdata;
                        wid_d = req_width;
                        off_d = dmem_addr[1:0];
                    end
                end
            end
            BUS: begin
                // Pipelined Wishbone: one strobe per access, cyc held until ack.
                stb_d = 1'b0;
                if (wb.wb_ack_i) begin
                    cyc_d   = 1'b0;
                    resp_d  = 1'b1;
                    rdata_d = we_q ? 32'h0 : steer_rdata;
                end else if (expire) begin
                    cyc_d   = 1'b0;
                    resp_d  = 1'b1;
                    err_d   = 1'b1;
                    rdata_d = '0;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cyc_q   <= 1'b0;
            stb_q   <= 1'b0;
            we_q    <= 1'b0;
            sel_q   <= 4'h0;
            adr_q   <= 32'h0;
            dat_q   <= 32'h0;
            rdata_q <= 32'h0;
            resp_q  <= 1'b0;
            err_q   <= 1'b0;
            wid_q   <= BYTE;
            off_q   <= 2'b00;
        end else begin
            cyc_q   <= cyc_d;
            stb_q   <= stb_d;
            we_q    <= we_d;
            sel_q   <= sel_d;
            adr_q   <= adr_d;
            dat_q   <= dat_d;
            rdata_q <= rdata_d;
            resp_q  <= resp_d;
            err_q   <= err_d;
            wid_q   <= wid_d;
            off_q   <= off_d;
        end
    end

    assign wb.wb_cyc_o = cyc_q;
    assign wb.wb_stb_o = stb_q;
    assign wb.wb_we_o  = we_q;
    assign wb.wb_sel_o = sel_q;
    assign wb.wb_adr_o = adr_q;
    assign wb.wb_dat_o = dat_q;
    assign dmem_rdata  = rdata_q;
    assign dmem_resp   = resp_q;
    assign dmem_err    = err_q;
endmodule

// File: tb/tb_rv3n_dmem_wb_bridge.sv
// tb/tb_rv3n_dmem_wb_bridge.sv - directed self-checking bench for rv3n_dmem_wb_bridge
module tb_rv3n_dmem_wb_bridge;
    logic        clk;
    logic        rst_n;
    logic        dmem_req;
    logic        dmem_cmd;
    logic [1:0]  dmem_width;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic [31:0] dmem_rdata;
    logic        dmem_resp;
    logic        dmem_err;
    int          checks;
    int          errors;

    rv3n_dmem_wb_bridge_if wb_if ();

    rv3n_dmem_wb_bridge #(.TIMEOUT_CYCLES(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .dmem_req   (dmem_req),
        .dmem_cmd   (dmem_cmd),
        .dmem_width (dmem_width),
        .dmem_addr  (dmem_addr),
        .dmem_wdata (dmem_wdata),
        .dmem_rdata (dmem_rdata),
        .dmem_resp  (dmem_resp),
        .dmem_err   (dmem_err),
        .wb         (wb_if.master)
    );

    // {cyc, stb, we, sel} and {resp, err} views for compact comparisons
    wire [6:0] ctl = {wb_if.wb_cyc_o, wb_if.wb_stb_o, wb_if.wb_we_o, wb_if.wb_sel_o};
    wire [1:0] rsp = {dmem_resp, dmem_err};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic cmd, input logic [1:0] w, input logic [31:0] a, input logic [31:0] d);
        dmem_req   = 1'b1;
        dmem_cmd   = cmd;
        dmem_width = w;
        dmem_addr  = a;
        dmem_wdata = d;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick();
        tick();
        checks++;
        if ({ctl, rsp} !== 9'h0) begin
            errors++; $display("FAIL reset_ctl: got %h expected 000", {ctl, rsp});
        end
        checks++;
        if ({wb_if.wb_adr_o, wb_if.wb_dat_o, dmem_rdata} !== 96'h0) begin
            errors++; $display("FAIL reset_data: got %h expected 0", {wb_if.wb_adr_o, wb_if.wb_dat_o, dmem_rdata});
        end
        #2 rst_n = 1'b1;
        tick();
    endtask

    task automatic test_word_read();
        issue(1'b0, 2'b10, 32'h0000_0100, 32'h0);
        tick();
        checks++;
        if (ctl !== 7'b110_1111 || wb_if.wb_adr_o !== 32'h100 || rsp !== 2'b00) begin
            errors++; $display("FAIL wrd_issue: got ctl=%b adr=%h rsp=%b expected ctl=1101111 adr=100 rsp=00", ctl, wb_if.wb_adr_o, rsp);
        end
        tick();
        checks++;
        if (ctl[6:5] !== 2'b10) begin
            errors++; $display("FAIL wrd_stb_drop: got cyc/stb=%b expected 10", ctl[6:5]);
        end
        tick();
        checks++;
        if (ctl[6:5] !== 2'b10 || rsp !== 2'b00) begin
            errors++; $display("FAIL wrd_wait: got cyc/stb=%b rsp=%b expected 10 00", ctl[6:5], rsp);
        end
        wb_if.wb_ack_i = 1'b1;
        wb_if.wb_dat_i = 32'hDEAD_BEEF;
        tick();
        wb_if.wb_ack_i = 1'b0;
        checks++;
        if (rsp !== 2'b10 || dmem_rdata !== 32'hDEAD_BEEF || ctl[6] !== 1'b0) begin
            errors++; $display("FAIL wrd_resp: got rsp=%b rdata=%h cyc=%b expected 10 deadbeef 0", rsp, dmem_rdata, ctl[6]);
        end
        dmem_req = 1'b0;
        tick();
        checks++;
        if (rsp !== 2'b00 || dmem_rdata !== 32'hDEAD_BEEF) begin
            errors++; $display("FAIL wrd_hold: got rsp=%b rdata=%h expected 00 deadbeef", rsp, dmem_rdata);
        end
    endtask

    task automatic test_byte_write();
        issue(1'b1, 2'b00, 32'h0000_0203, 32'h0000_00A5);
        tick();
        checks++;
        if (ctl !== 7'b111_1000 || wb_if.wb_adr_o !== 32'h200 || wb_if.wb_dat_o !== 32'hA5A5_A5A5) begin
            errors++; $display("FAIL bw_issue: got ctl=%b adr=%h dat=%h expected 1111000 200 a5a5a5a5", ctl, wb_if.wb_adr_o, wb_if.wb_dat_o);
        end
        wb_if.wb_ack_i = 1'b1;
        tick();
        wb_if.wb_ack_i = 1'b0;
        checks++;
        if (rsp !== 2'b10 || dmem_rdata !== 32'h0 || ctl[6:5] !== 2'b00) begin
            errors++; $display("FAIL bw_resp: got rsp=%b rdata=%h cyc/stb=%b expected 10 0 00", rsp, dmem_rdata, ctl[6:5]);
        end
        dmem_req = 1'b0;
        tick();
    endtask

    task automatic test_half_read();
        issue(1'b0, 2'b01, 32'h0000_0302, 32'h0);
        tick();
        checks++;
        if (ctl !== 7'b110_1100 || wb_if.wb_adr_o !== 32'h300) begin
            errors++; $display("FAIL hr_issue: got ctl=%b adr=%h expected 1101100 300", ctl, wb_if.wb_adr_o);
        end
        tick();
        wb_if.wb_ack_i = 1'b1;
        wb_if.wb_dat_i = 32'h1234_5678;
        tick();
        wb_if.wb_ack_i = 1'b0;
        checks++;
        if (rsp !== 2'b10 || dmem_rdata !== 32'h0000_1234) begin
            errors++; $display("FAIL hr_resp: got rsp=%b rdata=%h expected 10 00001234", rsp, dmem_rdata);
        end
        dmem_req = 1'b0;
        tick();
    endtask

    task automatic test_misaligned();
        logic [1:0]  w_tab [3];
        logic [31:0] a_tab [3];
        w_tab = '{2'b10, 2'b01, 2'b11};
        a_tab = '{32'h401, 32'h401, 32'h400};
        for (int i = 0; i < 3; i++) begin
            issue(1'b0, w_tab[i], a_tab[i], 32'h0);
            tick();
            checks++;
            if (ctl[6:5] !== 2'b00 || rsp !== 2'b11 || dmem_rdata !== 32'h0) begin
                errors++; $display("FAIL mis_%0d: got cyc/stb=%b rsp=%b rdata=%h expected 00 11 0", i, ctl[6:5], rsp, dmem_rdata);
            end
            dmem_req = 1'b0;
            tick();
            checks++;
            if (rsp !== 2'b00 || ctl[6] !== 1'b0) begin
                errors++; $display("FAIL mis_end_%0d: got rsp=%b cyc=%b expected 00 0", i, rsp, ctl[6]);
            end
        end
        // A stray ack in IDLE must not produce a response.
        wb_if.wb_ack_i = 1'b1;
        tick();
        wb_if.wb_ack_i = 1'b0;
        checks++;
        if (rsp !== 2'b00 || ctl[6] !== 1'b0) begin
            errors++; $display("FAIL idle_ack: got rsp=%b cyc=%b expected 00 0", rsp, ctl[6]);
        end
    endtask

    task automatic test_back_to_back();
        issue(1'b0, 2'b00, 32'h0000_0001, 32'h0);
        tick();
        checks++;
        if (ctl !== 7'b110_0010) begin
            errors++; $display("FAIL b2b_issue1: got ctl=%b expected 1100010", ctl);
        end
        wb_if.wb_ack_i = 1'b1;
        wb_if.wb_dat_i = 32'h0000_AB00;
        tick();
        wb_if.wb_ack_i = 1'b0;
        checks++;
        if (rsp !== 2'b10 || dmem_rdata !== 32'h0000_00AB) begin
            errors++; $display("FAIL b2b_resp1: got rsp=%b rdata=%h expected 10 000000ab", rsp, dmem_rdata);
        end
        tick();
        checks++;
        if (ctl[6:5] !== 2'b00 || rsp !== 2'b00) begin
            errors++; $display("FAIL b2b_idle: got cyc/stb=%b rsp=%b expected 00 00", ctl[6:5], rsp);
        end
        tick();
        checks++;
        if (ctl !== 7'b110_0010) begin
            errors++; $display("FAIL b2b_issue2: got ctl=%b expected 1100010", ctl);
        end
        wb_if.wb_ack_i = 1'b1;
        wb_if.wb_dat_i = 32'h0000_EF00;
        tick();
        wb_if.wb_ack_i = 1'b0;
        checks++;
        if (rsp !== 2'b10 || dmem_rdata !== 32'h0000_00EF) begin
            errors++; $display("FAIL b2b_resp2: got rsp=%b rdata=%h expected 10 000000ef", rsp, dmem_rdata);
        end
        dmem_req = 1'b0;
        tick();
    endtask

    task automatic test_reset_mid_bus();
        issue(1'b1, 2'b10, 32'h0000_0500, 32'h1122_3344);
        tick();
        checks++;
        if (ctl !== 7'b111_1111 || wb_if.wb_dat_o !== 32'h1122_3344) begin
            errors++; $display("FAIL rst_issue: got ctl=%b dat=%h expected 1111111 11223344", ctl, wb_if.wb_dat_o);
        end
        tick();
        dmem_req = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        checks++;
        if ({ctl, rsp} !== 9'h0 || {wb_if.wb_adr_o, wb_if.wb_dat_o, dmem_rdata} !== 96'h0) begin
            errors++; $display("FAIL rst_async: got ctl=%b rsp=%b adr=%h dat=%h rdata=%h expected all 0",
                               ctl, rsp, wb_if.wb_adr_o, wb_if.wb_dat_o, dmem_rdata);
        end
        #1 rst_n = 1'b1;
        wb_if.wb_ack_i = 1'b1;
        tick();
        wb_if.wb_ack_i = 1'b0;
        checks++;
        if (rsp !== 2'b00 || ctl[6] !== 1'b0) begin
            errors++; $display("FAIL rst_noresp1: got rsp=%b cyc=%b expected 00 0", rsp, ctl[6]);
        end
        tick();
        checks++;
        if (rsp !== 2'b00) begin
            errors++; $display("FAIL rst_noresp2: got rsp=%b expected 00", rsp);
        end
    endtask

`ifdef BRIDGE_TIMEOUT_EN
    task automatic test_timeout();
        issue(1'b0, 2'b10, 32'h0000_0600, 32'h0);
        for (int i = 1; i <= 8; i++) begin
            tick();
            checks++;
            if (ctl[6] !== 1'b1 || rsp !== 2'b00) begin
                errors++; $display("FAIL to_wait_%0d: got cyc=%b rsp=%b expected 1 00", i, ctl[6], rsp);
            end
        end
        tick();
        checks++;
        if (ctl[6] !== 1'b0 || rsp !== 2'b11 || dmem_rdata !== 32'h0) begin
            errors++; $display("FAIL to_expire: got cyc=%b rsp=%b rdata=%h expected 0 11 0", ctl[6], rsp, dmem_rdata);
        end
        dmem_req = 1'b0;
        tick();
        // Ack on the expiry cycle takes priority.
        issue(1'b0, 2'b10, 32'h0000_0604, 32'h0);
        for (int i = 1; i <= 8; i++) tick();
        wb_if.wb_ack_i = 1'b1;
        wb_if.wb_dat_i = 32'hCAFE_F00D;
        tick();
        wb_if.wb_ack_i = 1'b0;
        checks++;
        if (rsp !== 2'b10 || dmem_rdata !== 32'hCAFE_F00D) begin
            errors++; $display("FAIL to_ack_wins: got rsp=%b rdata=%h expected 10 cafef00d", rsp, dmem_rdata);
        end
        dmem_req = 1'b0;
        tick();
    endtask
`endif

    initial begin
        checks         = 0;
        errors         = 0;
        rst_n          = 1'b0;
        dmem_req       = 1'b0;
        dmem_cmd       = 1'b0;
        dmem_width     = 2'b00;
        dmem_addr      = 32'h0;
        dmem_wdata     = 32'h0;
        wb_if.wb_ack_i = 1'b0;
        wb_if.wb_dat_i = 32'h0;
        test_reset();
        test_word_read();
        test_byte_write();
        test_half_read();
        test_misaligned();
        test_back_to_back();
        test_reset_mid_bus();
`ifdef BRIDGE_TIMEOUT_EN
        test_timeout();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
